dram_read_requester: RTL and testbench
======================================

Name: dram_read_requester

Overview:
- AXI read-channel initiator that fetches a contiguous run of 256-bit DRAM lines for the accelerator.
- Accepts one command (start address, line count), splits it into AXI bursts, and issues them one at a time on the AR channel.
- Streams returned R-channel beats to a downstream consumer, with valid/ready backpressure passed through to RREADY.
- Sits between the sequence/reference fetch logic and the DRAM AXI slave (or its simulation stand-in).

Parameters:
- AXI_ID, 8'h00, value driven on axi_arid_out and expected on axi_rid_in.
- MAX_BURST, 16, maximum beats per burst (1..256).
- LEN_W, 16, width of the line-count field.

Ports:
- clk  in  1  system clock; also used as the AXI clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid_in  in  1  command valid.
- req_ready_out  out  1  command accepted when high with req_valid_in.
- req_addr_in  in  33  start byte address; bits [4:0] ignored and treated as 0.
- req_lines_in  in  LEN_W  number of 32-byte lines to read.
- axi_arready_in  in  1  AXI address ready.
- axi_arid_out  out  8  AXI address ID, equal to AXI_ID.
- axi_araddr_out  out  33  AXI burst address.
- axi_arlen_out  out  8  AXI burst length minus 1.
- axi_arvalid_out  out  1  AXI address valid.
- axi_rid_in  in  8  AXI read ID.
- axi_rvalid_in  in  1  AXI read data valid.
- axi_rdata_in  in  256  AXI read data.
- axi_rready_out  out  1  AXI read ready.
- data_valid_out  out  1  beat valid to consumer.
- data_out  out  256  beat data.
- data_ready_in  in  1  consumer ready.
- busy_out  out  1  high from command accept until done.
- done_out  out  1  one-cycle pulse when a command completes.

Behaviour:
- Reset (async, active-high): state=IDLE; all counters and registers cleared; every output driven 0 except axi_arid_out=AXI_ID.
- A reset mid-transfer abandons the transfer; any beats still in flight after reset are ignored because axi_rready_out=0.
- IDLE:
  - req_ready_out=1.
  - On req_valid_in, latch the address ({addr[32:5],5'b0}) and remaining=req_lines_in, then set busy_out=1.
  - If req_lines_in==0, go to DONE; otherwise go to ADDR.
- ADDR:
  - Burst beats computed at ADDR entry: beats = min(remaining, MAX_BURST, 128 - addr[11:5]). Bursts never cross a 4 KB boundary.
  - axi_arvalid_out=1, with axi_araddr_out=addr and axi_arlen_out=beats-1. These values are registered and stay stable until the handshake.
  - On axi_arready_in, go to DATA with beat_cnt=beats.
  - Only one burst is outstanding at any time.
- DATA:
  - axi_rready_out = data_ready_in.
  - data_valid_out = axi_rvalid_in.
  - data_out = axi_rdata_in (combinational, zero latency).
  - On each rvalid&rready: decrement beat_cnt and remaining; addr += 32 (33-bit wrap).
  - When the last beat of a burst transfers: go to DONE if remaining becomes 0, else go to ADDR.
  - No RLAST port exists; burst completion is determined only by beat count.
- DONE: done_out=1 for exactly one cycle; busy_out=0; next state IDLE. req_ready_out=0 in DONE.
- Outside DATA: axi_rready_out=0 and data_valid_out=0. Any axi_rvalid_in seen outside DATA is ignored.
- Address wrap: an address past 33'h1_FFFF_FFE0 wraps to 0. No error is raised.

Optional Feature:
- Macro: DRAM_READ_RID_CHECK_EN.
- When defined:
  - Adds output err_out (1 bit), reset 0.
  - Sticky set when a beat transfers with axi_rid_in != AXI_ID.
  - Cleared only on the next command accept.
  - The data is still forwarded.
- When undefined: the port is absent and axi_rid_in is unused.

Test Plan:
- Single line: req addr=0, lines=1, slave arready and rvalid one cycle after arvalid -> one AR with araddr=0, arlen=0; data_out=slave beat; done_out pulses once, 1 cycle after the beat.
- Multi-burst: addr=0, lines=40, MAX_BURST=16 -> three ARs:
  - araddr 0x000, arlen 15
  - araddr 0x200, arlen 15
  - araddr 0x400, arlen 7
  - 40 beats total, then done.
- 4 KB split: addr=0xFC0, lines=4 -> AR 0xFC0 arlen 1, then AR 0x1000 arlen 1.
- Backpressure: hold data_ready_in=0 for 5 cycles mid-burst while the slave holds rvalid -> axi_rready_out=0 for those cycles, no beat lost or duplicated, beat order preserved; arvalid/araddr held stable while arready=0 for 3 cycles.
- Zero length plus reset: lines=0 -> no arvalid, done_out one cycle after accept. Separately, assert rst in DATA after 2 of 8 beats -> all outputs 0 immediately, state IDLE, req_ready_out=1 after release.
- With DRAM_READ_RID_CHECK_EN: rid=8'h05 on beat 3 with AXI_ID=0 -> err_out=1 from that cycle until the next accept; data still delivered.

Source files
------------

// File: rtl/dram_read_requester.sv
// dram_read_requester: AXI read initiator splitting a line-count command into 4 KB-safe bursts.
// Optional build macro DRAM_READ_RID_CHECK_EN adds a sticky err_out for beats with an unexpected RID.
module dram_read_requester #(
  parameter logic [7:0] AXI_ID    = 8'h00,
  parameter int         MAX_BURST = 16,
  parameter int         LEN_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid_in,
  output logic             req_ready_out,
  input  logic [32:0]      req_addr_in,
  input  logic [LEN_W-1:0] req_lines_in,
  input  logic             axi_arready_in,
  output logic [7:0]       axi_arid_out,
  output logic [32:0]      axi_araddr_out,
  output logic [7:0]       axi_arlen_out,
  output logic             axi_arvalid_out,
  input  logic [7:0]       axi_rid_in,
  input  logic             axi_rvalid_in,
  input  logic [255:0]     axi_rdata_in,
  output logic             axi_rready_out,
  output logic             data_valid_out,
  output logic [255:0]     data_out,
  input  logic             data_ready_in,
  output logic             busy_out,
`ifdef DRAM_READ_RID_CHECK_EN
  output logic             err_out,
`endif
  output logic             done_out
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
  localparam logic [8:0] MB = 9'(MAX_BURST);

  logic [1:0]       state;
  logic [32:0]      addr;
  logic [LEN_W-1:0] remaining;
  logic [8:0]       beat_cnt;
  logic [32:0]      req_base;
  logic [32:0]      ld_addr;
  logic [LEN_W-1:0] ld_rem;
  logic [8:0]       ld_beats;
  logic             xfer;

  // Beats in the next burst: limited by work left, the burst cap and the distance to the 4 KB page end.
  function automatic logic [8:0] burst_beats(input logic [32:0] a, input logic [LEN_W-1:0] r);
    logic [8:0] to_4k;
    logic [8:0] cap;
    to_4k = 9'd128 - {2'b0, a[11:5]};
    cap   = (MB < to_4k) ? MB : to_4k;
    return (r < LEN_W'(cap)) ? 9'(r) : cap;
  endfunction

  assign req_base = {req_addr_in[32:5], 5'b0};
  assign xfer     = state == DATA && axi_rvalid_in && data_ready_in;
  // The next burst is computed from either the fresh command or the post-beat address/count.
  assign ld_addr  = (state == IDLE) ? req_base : addr + 33'd32;
  assign ld_rem   = (state == IDLE) ? req_lines_in : remaining - LEN_W'(1);
  assign ld_beats = burst_beats(ld_addr, ld_rem);

  assign axi_arid_out   = AXI_ID;
  assign req_ready_out  = state == IDLE && !rst;
  assign busy_out       = state == ADDR || state == DATA;
  assign done_out       = state == DONE;
  assign axi_rready_out = state == DATA && data_ready_in;
  assign data_valid_out = state == DATA && axi_rvalid_in;
  assign data_out       = (state == DATA) ? axi_rdata_in : '0;

  // Command sequencing: accept, issue one burst, drain its beats, repeat until the line count is exhausted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      addr            <= '0;
      remaining       <= '0;
      beat_cnt        <= '0;
      axi_arvalid_out <= 1'b0;
      axi_araddr_out  <= '0;
      axi_arlen_out   <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid_in) begin
          addr      <= req_base;
          remaining <= req_lines_in;
          if (req_lines_in == '0) state <= DONE;
          else begin
            state           <= ADDR;
            beat_cnt        <= ld_beats;
            axi_arvalid_out <= 1'b1;
            axi_araddr_out  <= ld_addr;
            axi_arlen_out   <= 8'(ld_beats - 9'd1);
          end
        end
        ADDR: if (axi_arready_in) begin
          axi_arvalid_out <= 1'b0;
          state           <= DATA;
        end
        DATA: if (xfer) begin
          addr      <= ld_addr;
          remaining <= ld_rem;
          beat_cnt  <= beat_cnt - 9'd1;
          if (beat_cnt == 9'd1) begin
            if (ld_rem == '0) state <= DONE;
            else begin
              state           <= ADDR;
              beat_cnt        <= ld_beats;
              axi_arvalid_out <= 1'b1;
              axi_araddr_out  <= ld_addr;
              axi_arlen_out   <= 8'(ld_beats - 9'd1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DRAM_READ_RID_CHECK_EN
  logic err_q;
  logic bad_beat;
  logic unused_bits;
  assign bad_beat    = xfer && axi_rid_in != AXI_ID;
  assign err_out     = err_q | bad_beat;
  assign unused_bits = ^req_addr_in[4:0];
  // Sticky RID error, flagged in the offending beat's own cycle and cleared by the next command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else if (state == IDLE && req_valid_in) err_q <= 1'b0;
    else if (bad_beat) err_q <= 1'b1;
  end
`else
  logic unused_bits;
  assign unused_bits = ^{req_addr_in[4:0], axi_rid_in};
`endif
endmodule

// File: tb/tb_dram_read_requester.sv
// tb_dram_read_requester: randomized AXI slave/consumer with a burst-plan reference model.
module tb_dram_read_requester;
  localparam logic [7:0] AXI_ID = 8'h00;
  localparam int MAX_BURST = 16;
  localparam int LEN_W = 16;

  typedef struct packed {logic [32:0] a; logic [7:0] len;} ar_t;

  logic clk = 1'b0, rst = 1'b1;
  logic req_valid_in = 1'b0, req_ready_out;
  logic [32:0] req_addr_in = '0;
  logic [LEN_W-1:0] req_lines_in = '0;
  logic axi_arready_in = 1'b0, axi_arvalid_out;
  logic [7:0] axi_arid_out, axi_arlen_out, axi_rid_in = AXI_ID;
  logic [32:0] axi_araddr_out;
  logic axi_rvalid_in = 1'b0, axi_rready_out;
  logic [255:0] axi_rdata_in = '0, data_out;
  logic data_valid_out, data_ready_in = 1'b0, busy_out, done_out;
`ifdef DRAM_READ_RID_CHECK_EN
  logic err_out;
  bit m_err;
`endif

  dram_read_requester #(.AXI_ID(AXI_ID), .MAX_BURST(MAX_BURST), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
    .req_addr_in(req_addr_in), .req_lines_in(req_lines_in), .axi_arready_in(axi_arready_in),
    .axi_arid_out(axi_arid_out), .axi_araddr_out(axi_araddr_out), .axi_arlen_out(axi_arlen_out),
    .axi_arvalid_out(axi_arvalid_out), .axi_rid_in(axi_rid_in), .axi_rvalid_in(axi_rvalid_in),
    .axi_rdata_in(axi_rdata_in), .axi_rready_out(axi_rready_out), .data_valid_out(data_valid_out),
    .data_out(data_out), .data_ready_in(data_ready_in), .busy_out(busy_out),
`ifdef DRAM_READ_RID_CHECK_EN
    .err_out(err_out),
`endif
    .done_out(done_out));

  always #5 clk = ~clk;

  int checks = 0, passed = 0;
  ar_t plan_q[$], exp_ar[$];
  bit m_idle = 1, m_busy = 0, m_done = 0, bp_hold = 0;
  int m_out = 0, m_left = 0, m_seq = 0, m_beats = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [255:0] beat_val(input int n);
    logic [31:0] x;
    x = 32'(n) * 32'h9E37_79B1 + 32'h1234_5678;
    return {x, ~x, x ^ 32'hFFFF_0000, x + 32'd1, x >> 1, x << 3, ~x + 32'd7, x};
  endfunction

  // Reference burst plan: walk the line run, cutting at the burst cap and at each 4 KB page end.
  task automatic build_plan(input logic [32:0] a0, input int lines);
    logic [32:0] a;
    int r, b, to4k;
    plan_q.delete();
    a = {a0[32:5], 5'b0};
    r = lines;
    while (r > 0) begin
      to4k = (4096 - int'(a[11:0])) / 32;
      b = r;
      if (b > MAX_BURST) b = MAX_BURST;
      if (b > to4k) b = to4k;
      plan_q.push_back('{a, 8'(b - 1)});
      a = a + 33'(b * 32);
      r -= b;
    end
  endtask

  // Slave and consumer: random AR/R handshakes, beats held until taken, spurious rvalid when idle.
  initial begin
    bit hs_ar, hs_r;
    logic [7:0] ar_len;
    int s_beats, s_seq;
    s_beats = 0;
    s_seq = 0;
    forever begin
      @(negedge clk);
      hs_ar = axi_arvalid_out && axi_arready_in;
      ar_len = axi_arlen_out;
      hs_r = axi_rvalid_in && axi_rready_out;
      @(posedge clk);
      #1;
      if (rst) begin
        s_beats = 0;
        s_seq = 0;
        axi_rvalid_in = 0;
      end else begin
        if (hs_ar) s_beats = int'(ar_len) + 1;
        if (hs_r) begin s_beats--; s_seq++; end
        axi_arready_in = $urandom_range(0, 3) != 0;
        data_ready_in = bp_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
`ifdef DRAM_READ_RID_CHECK_EN
        axi_rid_in = ($urandom_range(0, 15) == 0) ? 8'h05 : AXI_ID;
`endif
        if (s_beats > 0) begin
          if (!axi_rvalid_in || hs_r) axi_rvalid_in = $urandom_range(0, 3) != 0;
          axi_rdata_in = beat_val(s_seq);
        end else begin
          axi_rvalid_in = $urandom_range(0, 4) == 0;
          axi_rdata_in = {8{32'($urandom)}};
        end
      end
    end
  end

  // Compare process: every cycle, outputs against the model's view of the command in progress.
  always @(negedge clk) begin
    bit nd, xf, acc;
    if (rst) begin
      exp_ar.delete();
      m_idle = 1; m_busy = 0; m_done = 0; m_out = 0; m_left = 0; m_seq = 0; m_beats = 0;
`ifdef DRAM_READ_RID_CHECK_EN
      m_err = 0;
`endif
    end else begin
      xf = m_out > 0 && axi_rvalid_in && data_ready_in;
      acc = m_idle && req_valid_in && req_ready_out;
      chk("arid", axi_arid_out, AXI_ID);
      chk("req_ready", req_ready_out, m_idle);
      chk("busy", busy_out, m_busy);
      chk("done", done_out, m_done);
      chk("rready", axi_rready_out, m_out > 0 && data_ready_in);
      chk("data_valid", data_valid_out, m_out > 0 && axi_rvalid_in);
      if (axi_arvalid_out) begin
        chk("ar_expected", m_out == 0 && exp_ar.size() > 0, 1);
        if (exp_ar.size() > 0) begin
          chk("araddr", axi_araddr_out, exp_ar[0].a);
          chk("arlen", axi_arlen_out, exp_ar[0].len);
        end
      end
`ifdef DRAM_READ_RID_CHECK_EN
      chk("err", err_out, m_err || (xf && axi_rid_in != AXI_ID));
      if (xf && axi_rid_in != AXI_ID) m_err = 1;
`endif
      nd = 0;
      if (acc) begin
        build_plan(req_addr_in, int'(req_lines_in));
        exp_ar = plan_q;
        m_left = int'(req_lines_in);
        m_beats = 0;
        m_idle = 0;
`ifdef DRAM_READ_RID_CHECK_EN
        m_err = 0;
`endif
        if (req_lines_in == 0) nd = 1;
        else m_busy = 1;
      end
      if (axi_arvalid_out && axi_arready_in && exp_ar.size() > 0 && m_out == 0) begin
        m_out = int'(exp_ar[0].len) + 1;
        void'(exp_ar.pop_front());
      end
      if (xf) begin
        chk("data", data_out, beat_val(m_seq));
        m_seq++; m_out--; m_left--; m_beats++;
        if (m_left == 0) begin nd = 1; m_busy = 0; end
      end
      if (m_done) begin
        chk("plan_consumed", 32'(exp_ar.size() + m_out + m_left), 0);
        m_idle = 1;
      end
      m_done = nd;
    end
  end

  task automatic issue(input logic [32:0] a, input int lines);
    for (int i = 0; i < 3000 && !req_ready_out; i++) @(negedge clk);
    chk("ready_timeout", req_ready_out, 1);
    @(posedge clk);
    #1;
    req_valid_in = 1;
    req_addr_in = a;
    req_lines_in = LEN_W'(lines);
    @(posedge clk);
    #1;
    req_valid_in = 0;
    req_addr_in = {1'($urandom_range(0, 1)), 32'($urandom)};
    req_lines_in = LEN_W'($urandom);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 3000 && !done_out; i++) @(negedge clk);
    chk("done_timeout", done_out, 1);
  endtask

  task automatic wait_beats(input int n);
    for (int i = 0; i < 3000 && m_beats < n; i++) @(negedge clk);
    chk("beat_timeout", m_beats >= n, 1);
  endtask

  initial begin
    logic [32:0] a;
    int l, mode;
    build_plan(33'h0, 40);
    chk("plan40_n", 32'(plan_q.size()), 3);
    chk("plan40_a1", plan_q[1].a, 33'h200);
    chk("plan40_l1", plan_q[1].len, 8'd15);
    chk("plan40_a2", plan_q[2].a, 33'h400);
    chk("plan40_l2", plan_q[2].len, 8'd7);
    build_plan(33'hFC0, 4);
    chk("plan4k_l0", plan_q[0].len, 8'd1);
    chk("plan4k_a1", plan_q[1].a, 33'h1000);
    build_plan(33'h1_FFFF_FFDF, 4);
    chk("planwrap_a0", plan_q[0].a, 33'h1_FFFF_FFC0);
    chk("planwrap_a1", plan_q[1].a, 33'h0);
    build_plan(33'h40, 0);
    chk("plan0_n", 32'(plan_q.size()), 0);
    plan_q.delete();
    #1;
    chk("rst_ready", req_ready_out, 0);
    chk("rst_arvalid", axi_arvalid_out, 0);
    repeat (3) @(posedge clk);
    #3 rst = 0;
    issue(33'h0, 1);
    wait_done();
    issue(33'h0, 40);
    wait_beats(5);
    bp_hold = 1;
    repeat (5) @(posedge clk);
    bp_hold = 0;
    wait_done();
    issue(33'hFC0, 4);
    wait_done();
    issue(33'h1F, 0);
    wait_done();
    issue(33'h1_FFFF_FFC0, 4);
    wait_done();
    issue(33'h100, 8);
    wait_beats(2);
    @(posedge clk);
    #3 rst = 1;
    #1;
    chk("mid_rst_ready", req_ready_out, 0);
    chk("mid_rst_busy", busy_out, 0);
    chk("mid_rst_done", done_out, 0);
    chk("mid_rst_arvalid", axi_arvalid_out, 0);
    chk("mid_rst_araddr", axi_araddr_out, 0);
    chk("mid_rst_arlen", axi_arlen_out, 0);
    chk("mid_rst_rready", axi_rready_out, 0);
    chk("mid_rst_dvalid", data_valid_out, 0);
    chk("mid_rst_data", data_out, 0);
    chk("mid_rst_arid", axi_arid_out, AXI_ID);
    @(posedge clk);
    #3 rst = 0;
    #1;
    chk("post_rst_ready", req_ready_out, 1);
    for (int n = 0; n < 30; n++) begin
      mode = $urandom_range(0, 9);
      a = {1'($urandom_range(0, 1)), 32'($urandom)};
      l = $urandom_range(1, 40);
      if (mode == 0) l = 0;
      if (mode == 1) a[11:5] = 7'h7C;
      if (mode == 2) a = 33'h1_FFFF_FF00;
      issue(a, l);
      wait_done();
    end
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
